unified_memory_arbiter: RTL and testbench

- Shares one single-ported BSRAM_byte_en instance (1-cycle registered read) between the core's instruction-fetch and data-access requesters.
- Presents the same i_mem/d_mem handshake the core already drives, so the core sees two logical ports while the FPGA spends one BRAM port.
- Data side has priority. A bounded-streak fairness counter prevents fetch starvation.
- Returns read responses one cycle after acceptance, tagged to the requester that issued them.

---
 rtl/unified_memory_arbiter_pkg.sv | 28 ++
 rtl/unified_memory_arbiter_arb.sv | 41 ++++
 rtl/unified_memory_arbiter.sv | 108 ++++++++++
 tb/tb_unified_memory_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_memory_arbiter_pkg.sv
// Shared definitions for the unified memory arbiter.
//   clog2           : ceiling log2, used for byte-select and counter widths
//   owner_t         : tag of the requester owning the read response in flight
//   word_addr_bits  : width of the BSRAM word address for a given geometry
package unified_memory_arbiter_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < value) r = k + 1;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  function automatic int word_addr_bits(input int mem_address_bits, input int data_width);
    return mem_address_bits - clog2(data_width / 8);
  endfunction

  localparam int DEFAULT_WORD_ADDR_BITS = word_addr_bits(12, 32);

endpackage

// File: rtl/unified_memory_arbiter_arb.sv
// Two-requester fixed-priority arbiter with a bounded data streak.
// Data wins by default; after MAX_D_STREAK consecutive data grants with a
// fetch waiting, the fetch is forced through for one cycle.
//   clock, reset : clock and asynchronous active-high reset
//   d_req, i_req : data and fetch requests
//   grant_d/i    : combinational same-cycle grants
//   streak       : consecutive data grants while a fetch is pending
module fixed_priority_streak_arbiter
  import unified_memory_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  localparam int STREAK_W = clog2(MAX_D_STREAK + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                d_req,
  input  logic                i_req,
  output logic                grant_d,
  output logic                grant_i,
  output logic [STREAK_W-1:0] streak
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic force_i;

  assign force_i = i_req & (streak == STREAK_MAX);
  assign grant_i = i_req & (~d_req | force_i);
  assign grant_d = d_req & ~force_i;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      streak <= '0;
    end else if (grant_i || !i_req) begin
      streak <= '0;
    end else if (grant_d && (streak != STREAK_MAX)) begin
      streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/unified_memory_arbiter.sv
// Shares one single-ported, 1-cycle-latency byte-enable BSRAM between the
// instruction-fetch (i_mem_*) and data (d_mem_*) requesters of the core.
//   i_mem_* : fetch request in, ready/valid/data/address out
//   d_mem_* : data read/write request in, ready/valid/data/address out
//   mem_*   : drive toward the BSRAM port, mem_read_data returns from it
// Read responses come back exactly one cycle after acceptance, tagged with
// the requester that issued them; the read-data bus is shared.
module unified_memory_arbiter
  import unified_memory_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_BITS     = 32,
  parameter int MEM_ADDRESS_BITS = 12,
  parameter int MAX_D_STREAK     = 4,
  localparam int BYTES           = DATA_WIDTH / 8,
  localparam int BYTE_SEL        = clog2(BYTES),
  localparam int WORD_W          = word_addr_bits(MEM_ADDRESS_BITS, DATA_WIDTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_mem_read,
  input  logic [ADDRESS_BITS-1:0] i_mem_address_in,
  output logic [DATA_WIDTH-1:0]   i_mem_data_out,
  output logic [ADDRESS_BITS-1:0] i_mem_address_out,
  output logic                    i_mem_valid,
  output logic                    i_mem_ready,
  input  logic                    d_mem_read,
  input  logic                    d_mem_write,
  input  logic [BYTES-1:0]        d_mem_byte_en,
  input  logic [ADDRESS_BITS-1:0] d_mem_address_in,
  input  logic [DATA_WIDTH-1:0]   d_mem_data_in,
  output logic [DATA_WIDTH-1:0]   d_mem_data_out,
  output logic [ADDRESS_BITS-1:0] d_mem_address_out,
  output logic                    d_mem_valid,
  output logic                    d_mem_ready,
  output logic                    mem_read_en,
  output logic                    mem_write_en,
  output logic [BYTES-1:0]        mem_byte_en,
  output logic [WORD_W-1:0]       mem_word_address,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  input  logic [DATA_WIDTH-1:0]   mem_read_data
);

  logic d_req;
  logic grant_d;
  logic grant_i;
  logic d_read_grant;
  logic write_grant;
  logic [clog2(MAX_D_STREAK + 1)-1:0] streak;
  owner_t owner_next;
  owner_t resp_owner;

  assign d_req = d_mem_read | d_mem_write;

  fixed_priority_streak_arbiter #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_arb (
    .clock  (clock),
    .reset  (reset),
    .d_req  (d_req),
    .i_req  (i_mem_read),
    .grant_d(grant_d),
    .grant_i(grant_i),
    .streak (streak)
  );

  assign i_mem_ready = grant_i;
  assign d_mem_ready = grant_d;

  // A combined read+write is a write only; writes are blocked during reset.
  assign d_read_grant = grant_d & d_mem_read & ~d_mem_write;
  assign write_grant  = grant_d & d_mem_write & ~reset;

  assign mem_read_en      = d_read_grant | grant_i;
  assign mem_write_en     = write_grant;
  assign mem_byte_en      = write_grant ? d_mem_byte_en : '0;
  assign mem_write_data   = d_mem_data_in;
  assign mem_word_address = grant_d ? d_mem_address_in[MEM_ADDRESS_BITS-1:BYTE_SEL]
                                    : i_mem_address_in[MEM_ADDRESS_BITS-1:BYTE_SEL];

  always_comb begin
    owner_next = OWN_NONE;
    if (d_read_grant) begin
      owner_next = OWN_D;
    end else if (grant_i) begin
      owner_next = OWN_I;
    end
  end

  // Stage boundary: acceptance -> response, aligned with the BSRAM read register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_owner        <= OWN_NONE;
      i_mem_address_out <= '0;
      d_mem_address_out <= '0;
    end else begin
      resp_owner <= owner_next;
      if (grant_i) i_mem_address_out <= i_mem_address_in;
      if (d_read_grant) d_mem_address_out <= d_mem_address_in;
    end
  end

  assign i_mem_valid    = (resp_owner == OWN_I);
  assign d_mem_valid    = (resp_owner == OWN_D);
  assign i_mem_data_out = mem_read_data;
  assign d_mem_data_out = mem_read_data;

endmodule

// File: tb/tb_unified_memory_arbiter.sv
module tb_unified_memory_arbiter;

  localparam int MAXS = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_mem_read;
  logic [31:0] i_mem_address_in;
  logic [31:0] i_mem_data_out;
  logic [31:0] i_mem_address_out;
  logic        i_mem_valid;
  logic        i_mem_ready;
  logic        d_mem_read;
  logic        d_mem_write;
  logic [3:0]  d_mem_byte_en;
  logic [31:0] d_mem_address_in;
  logic [31:0] d_mem_data_in;
  logic [31:0] d_mem_data_out;
  logic [31:0] d_mem_address_out;
  logic        d_mem_valid;
  logic        d_mem_ready;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [3:0]  mem_byte_en;
  logic [9:0]  mem_word_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = 32'h0;

  logic [31:0] bram    [0:1023];
  logic [31:0] ref_mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  unified_memory_arbiter #(
    .DATA_WIDTH(32), .ADDRESS_BITS(32), .MEM_ADDRESS_BITS(12), .MAX_D_STREAK(MAXS)
  ) dut (
    .clock(clock), .reset(reset),
    .i_mem_read(i_mem_read), .i_mem_address_in(i_mem_address_in),
    .i_mem_data_out(i_mem_data_out), .i_mem_address_out(i_mem_address_out),
    .i_mem_valid(i_mem_valid), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_byte_en(d_mem_byte_en),
    .d_mem_address_in(d_mem_address_in), .d_mem_data_in(d_mem_data_in),
    .d_mem_data_out(d_mem_data_out), .d_mem_address_out(d_mem_address_out),
    .d_mem_valid(d_mem_valid), .d_mem_ready(d_mem_ready),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_byte_en(mem_byte_en),
    .mem_word_address(mem_word_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // BSRAM stand-in: registered read, byte-enable write.
  always @(posedge clock) begin
    if (mem_write_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_byte_en[b]) bram[mem_word_address][8*b +: 8] <= mem_write_data[8*b +: 8];
    end
    if (mem_read_en) mem_read_data <= bram[mem_word_address];
  end

  // Reference model: who owns the port this cycle, what each side must see next cycle.
  int          m_streak = 0;
  logic        m_i_vld = 1'b0, m_d_vld = 1'b0;
  logic [31:0] m_i_data = '0, m_d_data = '0, m_i_addr = '0, m_d_addr = '0;

  always @(negedge clock) begin : cmp
    logic ireq, dreq, frc, gi, gd, dread, dwrite;
    logic [31:0] ia, da;
    int s;
    if (reset) begin
      check("rst i_valid", i_mem_valid, 0);
      check("rst d_valid", d_mem_valid, 0);
      check("rst i_addr_out", i_mem_address_out, 0);
      check("rst d_addr_out", d_mem_address_out, 0);
    end else begin
      check("i_valid", i_mem_valid, m_i_vld);
      check("d_valid", d_mem_valid, m_d_vld);
      if (m_i_vld) check("i_data", i_mem_data_out, m_i_data);
      if (m_d_vld) check("d_data", d_mem_data_out, m_d_data);
      check("i_addr_out", i_mem_address_out, m_i_addr);
      check("d_addr_out", d_mem_address_out, m_d_addr);
    end
    ia = i_mem_address_in;
    da = d_mem_address_in;
    ireq = i_mem_read;
    dwrite = d_mem_write;
    dread = d_mem_read & ~dwrite;
    dreq = d_mem_read | d_mem_write;
    s = reset ? 0 : m_streak;
    frc = ireq && (s >= MAXS);
    gi = ireq && (!dreq || frc);
    gd = dreq && !frc;
    check("i_ready", i_mem_ready, gi);
    check("d_ready", d_mem_ready, gd);
    check("mem_read_en", mem_read_en, gi || (gd && dread));
    check("mem_write_en", mem_write_en, gd && dwrite && !reset);
    check("mem_byte_en", mem_byte_en, (gd && dwrite && !reset) ? d_mem_byte_en : 4'h0);
    if (gd) check("mem_addr d", mem_word_address, da[11:2]);
    else if (gi) check("mem_addr i", mem_word_address, ia[11:2]);
    if (reset) begin
      m_streak = 0; m_i_vld = 0; m_d_vld = 0; m_i_addr = 0; m_d_addr = 0;
    end else begin
      m_i_vld = gi;
      m_d_vld = gd && dread;
      if (gi) begin m_i_data = ref_mem[ia[11:2]]; m_i_addr = ia; end
      if (gd && dread) begin m_d_data = ref_mem[da[11:2]]; m_d_addr = da; end
      if (gd && dwrite)
        for (int b = 0; b < 4; b++)
          if (d_mem_byte_en[b]) ref_mem[da[11:2]][8*b +: 8] = d_mem_data_in[8*b +: 8];
      if (gi || !ireq) m_streak = 0;
      else if (gd && m_streak < MAXS) m_streak = m_streak + 1;
    end
  end

  task automatic preload(input int w, input logic [31:0] v);
    bram[w] = v;
    ref_mem[w] = v;
  endtask

  task automatic idle();
    i_mem_read = 0; d_mem_read = 0; d_mem_write = 0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    i_mem_address_in = 0; d_mem_address_in = 0; d_mem_data_in = 0; d_mem_byte_en = 0;
    for (int w = 0; w < 1024; w++) preload(w, 32'h0);
    preload(4, 32'hDEADBEEF);
    preload(16, 32'hA5A50040);
    preload(2, 32'h08080808);

    @(negedge clock);
    check("reset streak", dut.streak, 0);
    check("reset i_valid lit", i_mem_valid, 0);
    check("reset d_addr lit", d_mem_address_out, 0);
    next_cycle();
    reset = 0;

    // Fetch-only from 0x10
    for (int k = 0; k < 3; k++) begin
      i_mem_read = 1; i_mem_address_in = 32'h10;
      @(negedge clock);
      check("t1 i_ready", i_mem_ready, 1);
      if (k > 0) begin
        check("t1 i_valid", i_mem_valid, 1);
        check("t1 i_data", i_mem_data_out, 32'hDEADBEEF);
        check("t1 i_addr", i_mem_address_out, 32'h10);
      end
      next_cycle();
    end
    idle();
    @(negedge clock);
    check("t1 last i_valid", i_mem_valid, 1);
    check("t1 last i_data", i_mem_data_out, 32'hDEADBEEF);
    next_cycle();
    @(negedge clock);
    check("t1 after i_valid", i_mem_valid, 0);
    next_cycle();

    // Partial write then read back at 0x20
    d_mem_write = 1; d_mem_address_in = 32'h20; d_mem_data_in = 32'h00001234; d_mem_byte_en = 4'b0011;
    @(negedge clock);
    check("t2 d_ready", d_mem_ready, 1);
    check("t2 write_en", mem_write_en, 1);
    next_cycle();
    d_mem_write = 0; d_mem_read = 1;
    @(negedge clock);
    check("t2 no valid on write", d_mem_valid, 0);
    next_cycle();
    idle();
    @(negedge clock);
    check("t2 d_valid", d_mem_valid, 1);
    check("t2 d_data", d_mem_data_out, 32'h00001234);
    check("t2 d_addr", d_mem_address_out, 32'h20);
    next_cycle();

    // Continuous contention: D,D,D,D,I repeating
    i_mem_read = 1; i_mem_address_in = 32'h0C; d_mem_read = 1; d_mem_address_in = 32'h44;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      check("t3 i_ready", i_mem_ready, (k % 5) == 4);
      check("t3 d_ready", d_mem_ready, (k % 5) != 4);
      next_cycle();
    end
    idle();
    next_cycle();

    // Alternating D read at 0x40 and I fetch at 0x08
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        d_mem_read = 1; d_mem_address_in = 32'h40; i_mem_read = 0;
      end else begin
        i_mem_read = 1; i_mem_address_in = 32'h08; d_mem_read = 0;
      end
      @(negedge clock);
      if (k > 0) begin
        check("t4 d_valid", d_mem_valid, (k % 2) == 1);
        check("t4 i_valid", i_mem_valid, (k % 2) == 0);
        if (k % 2 == 1) check("t4 d_data", d_mem_data_out, 32'hA5A50040);
        else            check("t4 i_data", i_mem_data_out, 32'h08080808);
      end
      next_cycle();
    end
    idle();
    @(negedge clock);
    check("t4 last i_valid", i_mem_valid, 1);
    check("t4 last d_valid", d_mem_valid, 0);
    next_cycle();

    // Simultaneous read+write at 0x30 behaves as a write
    d_mem_read = 1; d_mem_write = 1; d_mem_address_in = 32'h30;
    d_mem_data_in = 32'hCAFEF00D; d_mem_byte_en = 4'hF;
    @(negedge clock);
    check("t5 write_en", mem_write_en, 1);
    check("t5 read_en", mem_read_en, 0);
    next_cycle();
    idle();
    @(negedge clock);
    check("t5 no d_valid", d_mem_valid, 0);
    check("t5 d_addr held", d_mem_address_out, 32'h40);
    next_cycle();
    d_mem_read = 1;
    next_cycle();
    idle();
    @(negedge clock);
    check("t5 readback", d_mem_data_out, 32'hCAFEF00D);
    check("t5 readback addr", d_mem_address_out, 32'h30);
    next_cycle();

    // Reset the cycle after an accepted data read
    d_mem_read = 1; d_mem_address_in = 32'h24; i_mem_read = 1; i_mem_address_in = 32'h10;
    next_cycle();
    idle();
    reset = 1;
    #1;
    check("t6 d_valid dropped", d_mem_valid, 0);
    check("t6 streak", dut.streak, 0);
    check("t6 d_addr", d_mem_address_out, 0);
    check("t6 i_addr", i_mem_address_out, 0);
    next_cycle();
    reset = 0;
    i_mem_read = 1; i_mem_address_in = 32'h10;
    @(negedge clock);
    check("t6 resume ready", i_mem_ready, 1);
    next_cycle();
    idle();
    @(negedge clock);
    check("t6 resume valid", i_mem_valid, 1);
    check("t6 resume data", i_mem_data_out, 32'hDEADBEEF);
    check("t6 resume addr", i_mem_address_out, 32'h10);
    next_cycle();
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
